// File: rtl/rv32v_types_pkg.sv
// Shared vector types for the element sequencer: element width, LMUL encoding,
// functional-unit tags, sequencer state, the micro-op bundle and the VLMAX helper.
package rv32v_types_pkg;
  localparam int PKG_VLEN      = 128;
  localparam int PKG_NUM_LANES = 2;
  localparam int VLENB         = PKG_VLEN / 8;
  localparam int LOG2_VLENB    = $clog2(VLENB);
  // Wide enough to hold VLMAX at SEW8/LMUL8 (== VLEN).
  localparam int OFF_W         = $clog2(PKG_VLEN) + 1;

  typedef logic [OFF_W-1:0] offset_t;
  typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2, SEW64 = 2'd3} sew_t;
  // 0..3 integer LMUL 1..8, 5..7 fractional 1/8..1/2, 4 reserved.
  typedef logic [2:0] vlmul_t;
  typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_DIV, FU_LSU} fu_t;
  typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_t;

  typedef struct packed {
    logic                                valid;
    logic [4:0]                          vd;
    logic [4:0]                          vs1;
    logic [4:0]                          vs2;
    logic [PKG_NUM_LANES-1:0][OFF_W-1:0] eidx;
    logic [PKG_NUM_LANES-1:0]            lane_active;
    fu_t                                 fu;
    logic                                last;
  } seq_uop_t;

  function automatic offset_t vlmax_f(input sew_t sew, input vlmul_t lmul);
    offset_t epr;
    epr = offset_t'(VLENB) >> sew;
    if (lmul[2]) return epr >> (4'd8 - {1'b0, lmul});
    else         return epr << lmul[1:0];
  endfunction
endpackage

// File: rtl/rv32v_elem_addr_calc.sv
// Per-lane element addressing for one micro-op starting at element e:
// group register (from lane 0), element index within the register, tail enable.
module rv32v_elem_addr_calc
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = PKG_NUM_LANES
) (
  input  logic [OFF_W:0]                   e,
  input  sew_t                             sew,
  input  offset_t                          n,
  input  logic [4:0]                       vd,
  input  logic [4:0]                       vs1,
  input  logic [4:0]                       vs2,
  output logic [4:0]                       reg_vd,
  output logic [4:0]                       reg_vs1,
  output logic [4:0]                       reg_vs2,
  output logic [NUM_LANES-1:0][OFF_W-1:0]  eidx,
  output logic [NUM_LANES-1:0]             tail_active
);
  localparam int EW = OFF_W + 1;

  logic [2:0]    sh;
  logic [EW-1:0] epr_mask;
  logic [4:0]    grp;

  // EPR is a power of two, so divide/modulo reduce to shift/mask.
  assign sh       = 3'(LOG2_VLENB) - {1'b0, sew};
  assign epr_mask = (EW'(1) << sh) - EW'(1);
  assign grp      = 5'(e >> sh);
  assign reg_vd   = vd + grp;
  assign reg_vs1  = vs1 + grp;
  assign reg_vs2  = vs2 + grp;

  for (genvar i = 0; i < NUM_LANES; i++) begin : lane_g
    logic [EW-1:0] k;
    assign k              = e + EW'(i);
    assign eidx[i]        = OFF_W'(k & epr_mask);
    assign tail_active[i] = k < {1'b0, n};
  end
endmodule

// File: rtl/rv32v_element_sequencer.sv
// Splits one decoded vector op into NUM_LANES-wide micro-ops over [vstart, min(vl,VLMAX)).
// Optional RV32V_MASK_SKIP_EN: apply v0 mask to lane enables and drop all-inactive
// non-final micro-ops. NUM_LANES must match the package default (micro-op struct width).
module rv32v_element_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = PKG_NUM_LANES,
  parameter int VLEN      = PKG_VLEN
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  sew_t                            sew,
  input  vlmul_t                          lmul,
  input  offset_t                         vl,
  input  offset_t                         vstart,
  input  logic [4:0]                      vd,
  input  logic [4:0]                      vs1,
  input  logic [4:0]                      vs2,
  input  logic                            vm,
  input  fu_t                             fu,
  input  logic [VLEN-1:0]                 v0_mask,
  output logic                            uop_valid,
  input  logic                            uop_ready,
  output logic [4:0]                      uop_vd,
  output logic [4:0]                      uop_vs1,
  output logic [4:0]                      uop_vs2,
  output logic [NUM_LANES-1:0][OFF_W-1:0] uop_eidx,
  output logic [NUM_LANES-1:0]            uop_lane_active,
  output fu_t                             uop_fu,
  output logic                            uop_last,
  output logic                            done,
  output logic                            illegal
);
  localparam int EW = OFF_W + 1;

  seq_state_t state_q, state_d;
  logic [EW-1:0] e_q;
  offset_t n_q;
  sew_t sew_q;
  logic [4:0] vd_q, vs1_q, vs2_q;
  fu_t fu_q;
  logic done_q, illegal_q;

  offset_t vlmax_in, n_in;
  logic cfg_bad, cfg_empty, issue_fire, start_run, advance, emit;
  logic last_c, skip_c;
  logic [4:0] reg_vd, reg_vs1, reg_vs2;
  logic [NUM_LANES-1:0][OFF_W-1:0] eidx_c;
  logic [NUM_LANES-1:0] tail_c, active_c;
  seq_uop_t uop_c;

  assign vlmax_in   = vlmax_f(sew, lmul);
  assign n_in       = (vl < vlmax_in) ? vl : vlmax_in;
  // A fractional group smaller than one micro-op cannot be sequenced.
  assign cfg_bad    = (sew > SEW32) || (lmul == 3'd4) ||
                      (lmul[2] && (vlmax_in < offset_t'(NUM_LANES)));
  assign cfg_empty  = n_in <= vstart;
  assign issue_fire = (state_q == SEQ_IDLE) && issue_valid;

  rv32v_elem_addr_calc #(.NUM_LANES(NUM_LANES)) u_addr (
    .e(e_q), .sew(sew_q), .n(n_q), .vd(vd_q), .vs1(vs1_q), .vs2(vs2_q),
    .reg_vd(reg_vd), .reg_vs1(reg_vs1), .reg_vs2(reg_vs2),
    .eidx(eidx_c), .tail_active(tail_c)
  );

  assign last_c = (e_q + EW'(NUM_LANES)) >= {1'b0, n_q};

`ifdef RV32V_MASK_SKIP_EN
  logic vm_q;
  logic [VLEN-1:0] mask_q;
  logic [NUM_LANES-1:0] mask_bits;
  for (genvar i = 0; i < NUM_LANES; i++) begin : mask_g
    logic [EW-1:0] k;
    assign k            = e_q + EW'(i);
    assign mask_bits[i] = mask_q[k[$clog2(VLEN)-1:0]];
  end
  assign active_c = tail_c & (vm_q ? {NUM_LANES{1'b1}} : mask_bits);
  // The final micro-op always goes out so uop_last reaches the lanes.
  assign skip_c   = ~|active_c && !last_c;

  // Mask context captured with the op.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vm_q   <= 1'b0;
      mask_q <= '0;
    end else if (start_run) begin
      vm_q   <= vm;
      mask_q <= v0_mask;
    end
  end
`else
  // Masking happens downstream; only the tail gates lanes.
  logic unused_mask;
  assign unused_mask = ^{vm, v0_mask};
  assign active_c    = tail_c;
  assign skip_c      = 1'b0;
`endif

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    issue_ready = 1'b0;
    emit        = 1'b0;
    advance     = 1'b0;
    start_run   = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && !cfg_bad && !cfg_empty) begin
          start_run = 1'b1;
          state_d   = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        emit = !skip_c;
        if (skip_c) advance = 1'b1;
        else if (uop_ready) begin
          advance = 1'b1;
          if (last_c) state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= SEQ_IDLE;
    else     state_q <= state_d;
  end

  // Op context, element counter and the completion / reject pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      e_q       <= '0;
      n_q       <= '0;
      sew_q     <= SEW8;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      fu_q      <= FU_ALU;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= (issue_fire && !cfg_bad && cfg_empty) || (emit && uop_ready && last_c);
      illegal_q <= issue_fire && cfg_bad;
      if (start_run) begin
        e_q   <= {1'b0, vstart};
        n_q   <= n_in;
        sew_q <= sew;
        vd_q  <= vd;
        vs1_q <= vs1;
        vs2_q <= vs2;
        fu_q  <= fu;
      end else if (advance) begin
        e_q <= e_q + EW'(NUM_LANES);
      end
    end
  end

  // Micro-op bundle, zeroed whenever nothing is offered.
  always_comb begin
    uop_c = '0;
    if (emit) begin
      uop_c.valid       = 1'b1;
      uop_c.vd          = reg_vd;
      uop_c.vs1         = reg_vs1;
      uop_c.vs2         = reg_vs2;
      uop_c.eidx        = eidx_c;
      uop_c.lane_active = active_c;
      uop_c.fu          = fu_q;
      uop_c.last        = last_c;
    end
  end

  assign uop_valid       = uop_c.valid;
  assign uop_vd          = uop_c.vd;
  assign uop_vs1         = uop_c.vs1;
  assign uop_vs2         = uop_c.vs2;
  assign uop_eidx        = uop_c.eidx;
  assign uop_lane_active = uop_c.lane_active;
  assign uop_fu          = uop_c.fu;
  assign uop_last        = uop_c.last;
  assign done            = done_q;
  assign illegal         = illegal_q;
endmodule

// File: tb/tb_rv32v_element_sequencer.sv
// Bench for rv32v_element_sequencer: directed and random ops against a list-of-micro-ops model.
module tb_rv32v_element_sequencer;
  import rv32v_types_pkg::*;

  logic CLK = 1'b0;
  logic RST, issue_valid, issue_ready, vm, uop_valid, uop_ready, uop_last, done, illegal;
  sew_t sew;
  vlmul_t lmul;
  offset_t vl, vstart;
  logic [4:0] vd, vs1, vs2, uop_vd, uop_vs1, uop_vs2;
  fu_t fu, uop_fu;
  logic [127:0] v0_mask;
  logic [1:0][OFF_W-1:0] uop_eidx;
  logic [1:0] uop_lane_active;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rv32v_element_sequencer dut (
    .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .sew(sew), .lmul(lmul), .vl(vl), .vstart(vstart), .vd(vd), .vs1(vs1), .vs2(vs2),
    .vm(vm), .fu(fu), .v0_mask(v0_mask), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_eidx(uop_eidx),
    .uop_lane_active(uop_lane_active), .uop_fu(uop_fu), .uop_last(uop_last),
    .done(done), .illegal(illegal)
  );

  typedef struct {
    int sew, lmul, vl, vstart, vd, vs1, vs2, fu, vm;
    logic [127:0] mask;
  } cfg_t;
  typedef struct {
    int vd, vs1, vs2, e0, e1, fu;
    logic [1:0] act;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int exp_kind;  // 0 run, 1 empty (done only), 2 illegal

  function automatic cfg_t mk(int s, int l, int vlen, int vst, int d, int r1, int r2,
                              int f, int m, logic [127:0] msk);
    cfg_t c;
    c.sew = s; c.lmul = l; c.vl = vlen; c.vstart = vst; c.vd = d; c.vs1 = r1; c.vs2 = r2;
    c.fu = f; c.vm = m; c.mask = msk;
    return c;
  endfunction

  // Expected micro-op list from the element arithmetic, written with plain division.
  function automatic void build(input cfg_t c);
    int epr, vlmax, n;
    exp_t u;
    exp_q.delete();
    epr = 16 / (1 << c.sew);
    if (c.lmul < 4) vlmax = epr * (1 << c.lmul);
    else            vlmax = epr / (1 << (8 - c.lmul));
    n = (c.vl < vlmax) ? c.vl : vlmax;
    if (c.sew > 2 || c.lmul == 4 || (c.lmul > 4 && vlmax < 2)) begin exp_kind = 2; return; end
    if (n <= c.vstart) begin exp_kind = 1; return; end
    exp_kind = 0;
    for (int e = c.vstart; e < n; e += 2) begin
      u.vd  = (c.vd + e / epr) % 32;
      u.vs1 = (c.vs1 + e / epr) % 32;
      u.vs2 = (c.vs2 + e / epr) % 32;
      u.e0  = e % epr;
      u.e1  = (e + 1) % epr;
      u.fu  = c.fu;
      for (int i = 0; i < 2; i++) begin
        u.act[i] = 1'b0;
        if (e + i < n) begin
`ifdef RV32V_MASK_SKIP_EN
          u.act[i] = (c.vm != 0) ? 1'b1 : c.mask[e + i];
`else
          u.act[i] = 1'b1;
`endif
        end
      end
      u.last = (e + 2 >= n);
`ifdef RV32V_MASK_SKIP_EN
      if (u.act == 2'b00 && !u.last) continue;
`endif
      exp_q.push_back(u);
    end
  endfunction

  task automatic drive_issue(input cfg_t c);
    sew = sew_t'(c.sew[1:0]); lmul = vlmul_t'(c.lmul[2:0]);
    vl = offset_t'(c.vl); vstart = offset_t'(c.vstart);
    vd = c.vd[4:0]; vs1 = c.vs1[4:0]; vs2 = c.vs2[4:0];
    fu = fu_t'(c.fu[1:0]); vm = c.vm[0]; v0_mask = c.mask;
    issue_valid = 1'b1;
  endtask

  // Issue one op at the current falling edge and follow it to completion.
  // Ends on the falling edge of the done/illegal pulse cycle so a caller may issue again.
  task automatic run_op(input string name, input cfg_t c, input int ready_pct, input int hold);
    int idx, cyc;
    exp_t x;
    build(c);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL %s issue_ready before issue got %b want 1", name, issue_ready);
    end
    drive_issue(c);
    @(negedge CLK);
    issue_valid = 1'b0;
    if (exp_kind != 0) begin
      checks++;
      if (illegal !== (exp_kind == 2) || done !== (exp_kind == 1) || uop_valid !== 1'b0 ||
          issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s pulse: illegal=%b done=%b uop_valid=%b issue_ready=%b want %b %b 0 1",
                 name, illegal, done, uop_valid, issue_ready, exp_kind == 2, exp_kind == 1);
      end
      return;
    end
    idx = 0; cyc = 0;
    while (idx < exp_q.size()) begin
      if (cyc > 400) begin
        checks++; errors++;
        $display("FAIL %s timeout after %0d uops, want %0d", name, idx, exp_q.size());
        uop_ready = 1'b0;
        return;
      end
      uop_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (uop_valid === 1'b1) begin
        x = exp_q[idx];
        checks++;
        if (uop_vd !== x.vd[4:0] || uop_vs1 !== x.vs1[4:0] || uop_vs2 !== x.vs2[4:0] ||
            uop_eidx[0] !== offset_t'(x.e0) || uop_eidx[1] !== offset_t'(x.e1) ||
            uop_lane_active !== x.act || uop_last !== x.last || uop_fu !== fu_t'(x.fu[1:0])) begin
          errors++;
          $display("FAIL %s uop%0d got vd=%0d vs1=%0d vs2=%0d eidx=%0d,%0d act=%b last=%b fu=%0d want vd=%0d vs1=%0d vs2=%0d eidx=%0d,%0d act=%b last=%b fu=%0d",
                   name, idx, uop_vd, uop_vs1, uop_vs2, uop_eidx[0], uop_eidx[1],
                   uop_lane_active, uop_last, uop_fu, x.vd, x.vs1, x.vs2, x.e0, x.e1,
                   x.act, x.last, x.fu);
        end
        checks++;
        if (done !== 1'b0 || illegal !== 1'b0 || issue_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s run flags uop%0d: done=%b illegal=%b issue_ready=%b want 0 0 0",
                   name, idx, done, illegal, issue_ready);
        end
        if (uop_ready) idx++;
      end else begin
`ifndef RV32V_MASK_SKIP_EN
        checks++; errors++;
        $display("FAIL %s uop_valid dropped at uop%0d got %b want 1", name, idx, uop_valid);
`endif
      end
      cyc++;
      @(negedge CLK);
    end
    uop_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || uop_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s completion: done=%b uop_valid=%b issue_ready=%b want 1 0 1",
               name, done, uop_valid, issue_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; issue_valid = 1'b0; uop_ready = 1'b0;
    drive_issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, '0));
    issue_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (issue_ready !== 1'b1 || uop_valid !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 ||
        uop_eidx !== '0 || uop_vd !== 5'd0 || uop_lane_active !== 2'b00 || uop_last !== 1'b0) begin
      errors++;
      $display("FAIL reset: issue_ready=%b uop_valid=%b done=%b illegal=%b eidx=%h vd=%0d want 1 0 0 0 0 0",
               issue_ready, uop_valid, done, illegal, uop_eidx, uop_vd);
    end
    @(negedge CLK);
  endtask

  task automatic test_basic();
    run_op("basic_sew32", mk(2, 0, 4, 0, 8, 3, 30, 1, 1, '0), 100, 0);
  endtask

  task automatic test_group();
    run_op("group_sew8_m2", mk(0, 1, 20, 0, 4, 10, 31, 2, 1, '0), 100, 0);
    run_op("group_sew16_m8", mk(1, 3, 70, 3, 28, 0, 5, 3, 1, '0), 80, 0);
  endtask

  task automatic test_tail();
    run_op("tail_vl3", mk(2, 0, 3, 0, 1, 2, 3, 0, 1, '0), 100, 0);
    run_op("vl_over_vlmax", mk(1, 0, 100, 0, 6, 7, 8, 0, 1, '0), 100, 0);
    run_op("frac_ok", mk(2, 7, 5, 0, 9, 9, 9, 1, 1, '0), 100, 0);
  endtask

  task automatic test_empty();
    run_op("vl_zero", mk(2, 0, 0, 0, 8, 0, 0, 0, 1, '0), 100, 0);
    run_op("vstart_past", mk(2, 0, 4, 5, 8, 0, 0, 0, 1, '0), 100, 0);
  endtask

  task automatic test_illegal();
    run_op("sew64", mk(3, 0, 4, 0, 0, 0, 0, 0, 1, '0), 100, 0);
    run_op("lmul_rsvd", mk(2, 4, 4, 0, 0, 0, 0, 0, 1, '0), 100, 0);
    run_op("frac_small", mk(2, 5, 4, 0, 0, 0, 0, 0, 1, '0), 100, 0);
  endtask

  task automatic test_backpressure();
    run_op("backpressure", mk(1, 0, 8, 0, 12, 13, 14, 2, 1, '0), 50, 3);
  endtask

  task automatic test_reset_mid();
    drive_issue(mk(0, 0, 16, 0, 2, 2, 2, 0, 1, '0));
    @(negedge CLK);
    issue_valid = 1'b0;
    uop_ready = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1; uop_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (issue_ready !== 1'b1 || uop_valid !== 1'b0 || done !== 1'b0 || uop_eidx !== '0) begin
      errors++;
      $display("FAIL reset_mid: issue_ready=%b uop_valid=%b done=%b eidx=%h want 1 0 0 0",
               issue_ready, uop_valid, done, uop_eidx);
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || uop_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after: done=%b uop_valid=%b want 0 0", done, uop_valid);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", mk(2, 0, 4, 0, 1, 1, 1, 0, 1, '0), 100, 0);
    run_op("b2b_b", mk(2, 0, 0, 0, 1, 1, 1, 0, 1, '0), 100, 0);
    run_op("b2b_c", mk(0, 0, 6, 1, 20, 21, 22, 3, 1, '0), 100, 0);
  endtask

`ifdef RV32V_MASK_SKIP_EN
  task automatic test_mask();
    run_op("mask_skip", mk(2, 0, 8, 0, 4, 4, 4, 0, 0, 128'hC1), 100, 0);
  endtask
`endif

  task automatic test_random();
    cfg_t c;
    for (int t = 0; t < 40; t++) begin
      c = mk((($urandom_range(9) == 0) ? 3 : $urandom_range(2)), $urandom_range(7),
             $urandom_range(140), (($urandom_range(3) == 0) ? $urandom_range(20) : 0),
             $urandom_range(31), $urandom_range(31), $urandom_range(31), $urandom_range(3),
             $urandom_range(1), {$urandom, $urandom, $urandom, $urandom});
      run_op($sformatf("rand%0d", t), c, 70, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_group();
    test_tail();
    test_empty();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef RV32V_MASK_SKIP_EN
    test_mask();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
